alu_result_serializer: RTL and testbench

Transmit-side formatter for the UART/ALU bridge. Takes a 32-bit ALU result, converts it to ASCII decimal (optional leading minus sign, no leading zeros), and feeds it byte by byte to the UART transmitter through a tx_start/tx_done handshake. A delimiter byte follows the last digit. This is the mirror of the ASCII-number receive path: it produces the same textual format the receive side parses.

---
 rtl/alu_result_serializer_if.sv | 21 ++
 rtl/alu_result_serializer.sv | 187 ++++++++++++++++++
 tb/tb_alu_result_serializer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_serializer_if.sv
// Handshake bundle between the ALU-result producer / UART TX side and the serializer.
// master: drives the request and the UART tx_done; slave: the serializer itself.
interface alu_result_serializer_if;
    logic        start;
    logic [31:0] data_in;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        done;

    modport master (
        output start, data_in, tx_done,
        input  tx_data, tx_start, busy, done
    );

    modport slave (
        input  start, data_in, tx_done,
        output tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/alu_result_serializer.sv
// Converts a 32-bit ALU result to ASCII decimal (optional '-', no leading zeros) followed by
// a delimiter byte, and hands the bytes one at a time to the UART TX via tx_start/tx_done.
module alu_result_serializer #(
    parameter bit         SIGNED = 1'b1,
    parameter logic [7:0] DELIM  = 8'h20
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_result_serializer_if.slave io_bus
);
    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StLoad,
        StStart,
        StWait,
        StFinish
    } state_e;

    state_e      r_state, w_state_next;
    logic        r_neg, w_neg_next;
    logic [31:0] r_mag, w_mag_next;
    logic [39:0] r_bcd, w_bcd_next;
    logic [4:0]  r_cnt, w_cnt_next;
    logic [3:0]  r_ptr, w_ptr_next;
    logic [7:0]  r_tx_data, w_tx_data_next;
    logic        r_tx_start, w_tx_start_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        r_tx_done_prev;

    logic        w_in_neg;
    logic [31:0] w_in_mag;
    logic [38:0] w_bcd_adj;
    logic [3:0]  w_first;
    logic [3:0]  w_last;
    logic [3:0]  w_didx;
    logic [3:0]  w_digit;
    logic [7:0]  w_byte;
    logic        w_tx_edge;

    // Two's-complement negate as unsigned, so 0x80000000 yields 2147483648.
    assign w_in_neg  = SIGNED & io_bus.data_in[31];
    assign w_in_mag  = w_in_neg ? (32'd0 - io_bus.data_in) : io_bus.data_in;
    assign w_tx_edge = io_bus.tx_done & ~r_tx_done_prev;

    // Double-dabble add-3 step. The top nibble only feeds its low three bits into the shift
    // and never reaches 5 for a 32-bit input (it is at most 2 before the final shift).
    always_comb begin
        w_bcd_adj = r_bcd[38:0];
        for (int i = 0; i < 9; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Index of the most significant nonzero digit; 0 when the value is zero.
    always_comb begin
        w_first = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_first = 4'(i);
            end
        end
    end

    // Byte sequence: [sign], digits first..0, DELIM; r_ptr walks it from 0 to w_last.
    assign w_last = w_first + {3'b000, r_neg} + 4'd1;
    assign w_didx = w_first + {3'b000, r_neg} - r_ptr;

    // Select the BCD digit addressed by the byte pointer.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_didx == 4'(i)) begin
                w_digit = r_bcd[4*i +: 4];
            end
        end
    end

    // Map the pointer position to the outgoing ASCII byte.
    always_comb begin
        if (r_ptr == w_last) begin
            w_byte = DELIM;
        end else if (r_neg && (r_ptr == 4'd0)) begin
            w_byte = 8'h2D;
        end else begin
            w_byte = {4'h3, w_digit};
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_next    = r_state;
        w_neg_next      = r_neg;
        w_mag_next      = r_mag;
        w_bcd_next      = r_bcd;
        w_cnt_next      = r_cnt;
        w_ptr_next      = r_ptr;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_neg_next   = w_in_neg;
                    w_mag_next   = w_in_mag;
                    w_bcd_next   = 40'd0;
                    w_cnt_next   = 5'd0;
                    w_ptr_next   = 4'd0;
                    w_busy_next  = 1'b1;
                    w_state_next = StConvert;
                end
            end
            StConvert: begin
                w_bcd_next = {w_bcd_adj, r_mag[31]};
                w_mag_next = {r_mag[30:0], 1'b0};
                w_cnt_next = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_tx_data_next = w_byte;
                w_state_next   = StStart;
            end
            StStart: begin
                w_tx_start_next = 1'b1;
                w_state_next    = StWait;
            end
            StWait: begin
                if (w_tx_edge) begin
                    if (r_ptr == w_last) begin
                        w_done_next  = 1'b1;
                        w_state_next = StFinish;
                    end else begin
                        w_ptr_next   = r_ptr + 4'd1;
                        w_state_next = StLoad;
                    end
                end
            end
            StFinish: begin
                w_busy_next  = 1'b0;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= StIdle;
            r_neg          <= 1'b0;
            r_mag          <= 32'd0;
            r_bcd          <= 40'd0;
            r_cnt          <= 5'd0;
            r_ptr          <= 4'd0;
            r_tx_data      <= 8'h00;
            r_tx_start     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_tx_done_prev <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_neg          <= w_neg_next;
            r_mag          <= w_mag_next;
            r_bcd          <= w_bcd_next;
            r_cnt          <= w_cnt_next;
            r_ptr          <= w_ptr_next;
            r_tx_data      <= w_tx_data_next;
            r_tx_start     <= w_tx_start_next;
            r_busy         <= w_busy_next;
            r_done         <= w_done_next;
            r_tx_done_prev <= io_bus.tx_done;
        end
    end

    assign io_bus.tx_data  = r_tx_data;
    assign io_bus.tx_start = r_tx_start;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: a signed and an unsigned instance, vector table with a
// byte scoreboard, plus hand-written handshake and reset corner cases.
module tb_alu_result_serializer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_u;
    logic        tb_start;
    logic [31:0] tb_data;
    logic        tb_tx_done;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];

    alu_result_serializer_if bus_s ();
    alu_result_serializer_if bus_u ();

    assign bus_s.start   = tb_start & ~sel_u;
    assign bus_u.start   = tb_start & sel_u;
    assign bus_s.data_in = tb_data;
    assign bus_u.data_in = tb_data;
    assign bus_s.tx_done = tb_tx_done;
    assign bus_u.tx_done = tb_tx_done;

    logic       m_tx_start, m_busy, m_done;
    logic [7:0] m_tx_data;
    assign m_tx_start = sel_u ? bus_u.tx_start : bus_s.tx_start;
    assign m_busy     = sel_u ? bus_u.busy     : bus_s.busy;
    assign m_done     = sel_u ? bus_u.done     : bus_s.done;
    assign m_tx_data  = sel_u ? bus_u.tx_data  : bus_s.tx_data;

    alu_result_serializer #(.SIGNED(1'b1), .DELIM(8'h20)) dut_s (
        .clk    (clk),
        .reset  (rst_n),
        .io_bus (bus_s)
    );

    alu_result_serializer #(.SIGNED(1'b0), .DELIM(8'h20)) dut_u (
        .clk    (clk),
        .reset  (rst_n),
        .io_bus (bus_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Push the right-justified ASCII record onto the scoreboard; returns its byte count.
    function automatic int push_expected(input logic [95:0] exp);
        int n = 0;
        for (int k = 11; k >= 0; k--) begin
            if (n == 0 && exp[8*k +: 8] != 8'h00) n = k + 1;
        end
        for (int j = 0; j < n; j++) sb.push_back(exp[8*(n-1-j) +: 8]);
        return n;
    endfunction

    // Scoreboard monitor: every tx_start must carry the next expected byte.
    always @(negedge clk) begin
        if (rst_n && m_tx_start) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte: got %02h, expected no byte", m_tx_data);
            end else begin
                check("byte", 32'(m_tx_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic wait_tx_start(input string name);
        bit ok = 1'b0;
        for (int b = 0; b < 100 && !ok; b++) begin
            @(negedge clk);
            if (m_tx_start) ok = 1'b1;
        end
        check({name, " tx_start_seen"}, 32'(ok), 1);
    endtask

    // One full result: start, UART responder with the given gap, timing and done checks.
    // Called and returns at a falling edge with the DUT idle.
    task automatic run_txn(input string name, input bit use_u, input logic [31:0] data,
                           input logic [95:0] exp, input int gap, input bit spurious,
                           input bit extra);
        int         n, sent, since, budget, start_cyc;
        bit         got_done;
        logic [7:0] held;
        n         = push_expected(exp);
        sel_u     = use_u;
        tb_data   = data;
        tb_start  = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        tb_start = 1'b0;
        if (spurious) begin
            repeat (4) @(negedge clk);
            tb_tx_done = 1'b1;
            @(negedge clk);
            tb_tx_done = 1'b0;
        end
        sent     = 0;
        since    = -1;
        budget   = 0;
        got_done = 1'b0;
        while (!got_done && budget < 2000) begin
            tb_start = 1'b0;
            if (m_done) begin
                got_done = 1'b1;
            end else if (m_tx_start) begin
                if (sent == 0) check({name, " first_latency"}, cyc - start_cyc, 34);
                else check({name, " next_latency"}, since, 2);
                held = m_tx_data;
                repeat (gap) @(negedge clk);
                check({name, " tx_data_hold"}, 32'(m_tx_data), 32'(held));
                tb_tx_done = 1'b1;
                @(negedge clk);
                tb_tx_done = 1'b0;
                sent++;
                since = 0;
                budget += gap + 1;
            end else begin
                if (extra && (budget % 9 == 4)) begin
                    tb_data  = 32'd98765;
                    tb_start = 1'b1;
                end
                @(negedge clk);
                budget++;
                if (since >= 0) since++;
            end
        end
        tb_start = 1'b0;
        check({name, " done_seen"}, 32'(got_done), 1);
        check({name, " byte_count"}, sent, n);
        check({name, " scoreboard_empty"}, sb.size(), 0);
        check({name, " busy_at_done"}, 32'(m_busy), 1);
        @(negedge clk);
        check({name, " done_width"}, 32'(m_done), 0);
        check({name, " busy_after_done"}, 32'(m_busy), 0);
    endtask

    typedef struct {
        bit          use_u;
        logic [31:0] data;
        logic [95:0] exp;
        int          gap;
        bit          spurious;
        bit          extra;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    initial begin
        int cnt;
        vecs[0]  = '{1'b0, 32'd123,        96'("123 "),         5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'd0,          96'("0 "),           5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'hFFFF_FFFB,  96'("-5 "),          3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0000,  96'("-2147483648 "), 2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF,  96'("4294967295 "),  4, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  96'("2147483648 "),  1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h7FFF_FFFF,  96'("2147483647 "),  0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'd1000000000, 96'("1000000000 "),  2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFF6,  96'("-10 "),         3, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'd10,         96'("10 "),          0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd123,        96'("123 "),         6, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'd9,          96'("9 "),           2, 1'b1, 1'b0};

        rst_n      = 1'b0;
        sel_u      = 1'b0;
        tb_start   = 1'b0;
        tb_data    = 32'd0;
        tb_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset s tx_data",  32'(bus_s.tx_data), 0);
        check("reset s tx_start", 32'(bus_s.tx_start), 0);
        check("reset s busy",     32'(bus_s.busy), 0);
        check("reset s done",     32'(bus_s.done), 0);
        check("reset u tx_data",  32'(bus_u.tx_data), 0);
        check("reset u tx_start", 32'(bus_u.tx_start), 0);
        check("reset u busy",     32'(bus_u.busy), 0);
        check("reset u done",     32'(bus_u.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].use_u, vecs[i].data, vecs[i].exp,
                    vecs[i].gap, vecs[i].spurious, vecs[i].extra);
        end

        // tx_done held high across LOAD/START of the second byte must not advance it.
        sel_u = 1'b0;
        void'(push_expected(96'("45 ")));
        tb_data  = 32'd45;
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        wait_tx_start("hold b0");
        tb_tx_done = 1'b1;
        wait_tx_start("hold b1");
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_tx_start) cnt++;
        end
        check("hold no_advance", cnt, 0);
        check("hold busy", 32'(m_busy), 1);
        tb_tx_done = 1'b0;
        @(negedge clk);
        tb_tx_done = 1'b1;
        @(negedge clk);
        tb_tx_done = 1'b0;
        wait_tx_start("hold b2");
        tb_tx_done = 1'b1;
        @(negedge clk);
        tb_tx_done = 1'b0;
        check("hold done", 32'(m_done), 1);
        @(negedge clk);
        check("hold busy_after", 32'(m_busy), 0);
        check("hold scoreboard_empty", sb.size(), 0);

        // Reset while the second byte is outstanding, then a fresh result.
        void'(push_expected(96'("12")));
        tb_data  = 32'd123;
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        wait_tx_start("rst b0");
        tb_tx_done = 1'b1;
        @(negedge clk);
        tb_tx_done = 1'b0;
        wait_tx_start("rst b1");
        #1 rst_n = 1'b0;
        #1;
        check("midreset tx_start", 32'(bus_s.tx_start), 0);
        check("midreset busy",     32'(bus_s.busy), 0);
        check("midreset tx_data",  32'(bus_s.tx_data), 0);
        check("midreset done",     32'(bus_s.done), 0);
        check("midreset scoreboard_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn("after_reset", 1'b0, 32'd7, 96'("7 "), 3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
